// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core control blocks.
package mips_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2,
    STEP   = 2'd3
  } state_t;

  localparam logic [4:0]  REG_ZERO             = 5'd0;
  localparam int unsigned DRAIN_CYCLES_DEFAULT = 3;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline/debug bundle between the datapath and the hazard controller.
interface hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16
);

  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rt;
  logic             id_is_branch;
  logic             id_branch_taken;
  logic             ex_mem_read;
  logic             ex_reg_write;
  logic [4:0]       ex_dest;
  logic             mem_mem_read;
  logic [4:0]       mem_dest;
  logic             dbg_halt_req;
  logic             dbg_step_req;
  logic             dbg_resume_req;

  logic             pc_write;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_bubble;
  logic             halted;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  // Datapath / debug unit side
  modport master (
    output id_rs, id_rt, id_uses_rt, id_is_branch, id_branch_taken,
           ex_mem_read, ex_reg_write, ex_dest, mem_mem_read, mem_dest,
           dbg_halt_req, dbg_step_req, dbg_resume_req,
    input  pc_write, if_id_write, if_id_flush, id_ex_bubble, halted,
           stall_count, flush_count
  );

  // Hazard controller side
  modport slave (
    input  id_rs, id_rt, id_uses_rt, id_is_branch, id_branch_taken,
           ex_mem_read, ex_reg_write, ex_dest, mem_mem_read, mem_dest,
           dbg_halt_req, dbg_step_req, dbg_resume_req,
    output pc_write, if_id_write, if_id_flush, id_ex_bubble, halted,
           stall_count, flush_count
  );

endinterface

// File: rtl/hazard_detect.sv
// Combinational register-dependency hazard detection for the ID stage.
module hazard_detect
  import mips_pkg::*;
(
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic       id_is_branch,
  input  logic       ex_mem_read,
  input  logic       ex_reg_write,
  input  logic [4:0] ex_dest,
  input  logic       mem_mem_read,
  input  logic [4:0] mem_dest,
  output logic       hazard
);

  logic ex_match;
  logic mem_match;

  // $zero never creates a dependency; rt only counts when it is a source.
  function automatic logic reg_match(input logic [4:0] dest,
                                     input logic [4:0] rs,
                                     input logic [4:0] rt,
                                     input logic       uses_rt);
    return (dest != REG_ZERO) && ((dest == rs) || (uses_rt && (dest == rt)));
  endfunction

  // Load-use, branch-on-ALU-result and branch-on-load dependencies.
  always_comb begin
    ex_match  = reg_match(ex_dest, id_rs, id_rt, id_uses_rt);
    mem_match = reg_match(mem_dest, id_rs, id_rt, id_uses_rt);
    hazard    = (ex_mem_read && ex_match)
             || (id_is_branch && ex_reg_write && ex_match)
             || (id_is_branch && mem_mem_read && mem_match);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline stall/flush control with debug halt/step/resume and event counters.
module hazard_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEFAULT,
  parameter int unsigned CNT_W        = 16
) (
  input  logic          clk,
  input  logic          reset,
  hazard_ctrl_if.slave  bus
);

  localparam int unsigned DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

  state_t           state;
  logic [DW-1:0]    drain_cnt;
  logic             hazard;
  logic             active;
  logic             flush;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  hazard_detect u_detect (
    .id_rs        (bus.id_rs),
    .id_rt        (bus.id_rt),
    .id_uses_rt   (bus.id_uses_rt),
    .id_is_branch (bus.id_is_branch),
    .ex_mem_read  (bus.ex_mem_read),
    .ex_reg_write (bus.ex_reg_write),
    .ex_dest      (bus.ex_dest),
    .mem_mem_read (bus.mem_mem_read),
    .mem_dest     (bus.mem_dest),
    .hazard       (hazard)
  );

  // Pipeline enables: reset is folded in so the pipe is frozen while reset is held,
  // not just after the registered state has cleared.
  always_comb begin
    active           = !reset && ((state == RUN) || (state == STEP));
    flush            = active && !hazard && bus.id_branch_taken;
    bus.pc_write     = active && !hazard;
    bus.if_id_write  = active && !hazard;
    bus.id_ex_bubble = !active || hazard;
    bus.if_id_flush  = flush;
    bus.halted       = !reset && (state == HALTED);
    bus.stall_count  = stall_cnt;
    bus.flush_count  = flush_cnt;
  end

  // Debug state machine and drain timer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= RUN;
      drain_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (bus.dbg_halt_req) begin
            state     <= DRAIN;
            drain_cnt <= '0;
          end
        end
        DRAIN: begin
          if (drain_cnt == DRAIN_LAST) state <= HALTED;
          else                         drain_cnt <= drain_cnt + DW'(1);
        end
        HALTED: begin
          if (bus.dbg_resume_req)    state <= RUN;
          else if (bus.dbg_step_req) state <= STEP;
        end
        STEP:    state <= HALTED;
        default: state <= RUN;
      endcase
    end
  end

  // Saturating stall/flush statistics, counted only while the pipe is live.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (active && hazard && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush && (flush_cnt != '1))            flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl.
module tb_hazard_ctrl;

  typedef struct {
    string tag;
    logic  pw;
    logic  ifw;
    logic  fl;
    logic  bub;
    logic  hl;
  } exp_t;

  logic clk;
  logic reset;
  int   passed;
  int   total;
  exp_t sb[$];

  hazard_ctrl_if #(.CNT_W(16)) bus ();

  hazard_ctrl #(.DRAIN_CYCLES(3), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic clear();
    bus.id_rs = 5'd0; bus.id_rt = 5'd0; bus.id_uses_rt = 1'b0;
    bus.id_is_branch = 1'b0; bus.id_branch_taken = 1'b0;
    bus.ex_mem_read = 1'b0; bus.ex_reg_write = 1'b0; bus.ex_dest = 5'd0;
    bus.mem_mem_read = 1'b0; bus.mem_dest = 5'd0;
    bus.dbg_halt_req = 1'b0; bus.dbg_step_req = 1'b0; bus.dbg_resume_req = 1'b0;
  endtask

  task automatic compare_head();
    exp_t e;
    e = sb.pop_front();
    check({e.tag, ".pc_write"},     {31'd0, bus.pc_write},     {31'd0, e.pw});
    check({e.tag, ".if_id_write"},  {31'd0, bus.if_id_write},  {31'd0, e.ifw});
    check({e.tag, ".if_id_flush"},  {31'd0, bus.if_id_flush},  {31'd0, e.fl});
    check({e.tag, ".id_ex_bubble"}, {31'd0, bus.id_ex_bubble}, {31'd0, e.bub});
    check({e.tag, ".halted"},       {31'd0, bus.halted},       {31'd0, e.hl});
  endtask

  // One cycle: expected outputs queued with the stimulus, compared mid-cycle,
  // then the clock edge is taken.
  task automatic step(input string tag, input logic pw, input logic ifw,
                      input logic fl, input logic bub, input logic hl);
    exp_t e;
    e.tag = tag; e.pw = pw; e.ifw = ifw; e.fl = fl; e.bub = bub; e.hl = hl;
    sb.push_back(e);
    @(negedge clk);
    compare_head();
    @(posedge clk); #1;
  endtask

  task automatic check_counts(input string tag, input int stall, input int fl);
    check({tag, ".stall_count"}, {16'd0, bus.stall_count}, stall);
    check({tag, ".flush_count"}, {16'd0, bus.flush_count}, fl);
  endtask

  task automatic load_use_inputs();
    bus.ex_mem_read = 1'b1; bus.ex_dest = 5'd2; bus.id_rs = 5'd2;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    reset  = 1'b1;
    clear();

    // Reset state, held across a clock edge.
    @(posedge clk); #2;
    sb.push_back('{"reset", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    compare_head();
    check_counts("reset", 0, 0);
    #5 reset = 1'b0;
    @(posedge clk); #1;

    step("idle", 1, 1, 0, 0, 0);
    check_counts("idle", 0, 0);

    // Load-use on rs.
    load_use_inputs();
    step("load_use", 0, 0, 0, 1, 0);
    clear();
    step("after_load_use", 1, 1, 0, 0, 0);
    check_counts("load_use", 1, 0);

    // Destination $zero never matches.
    bus.ex_mem_read = 1'b1; bus.ex_dest = 5'd0; bus.id_rs = 5'd0;
    step("dest_zero", 1, 1, 0, 0, 0);
    // rt only counts when used as a source.
    bus.ex_dest = 5'd2; bus.id_rs = 5'd5; bus.id_rt = 5'd2; bus.id_uses_rt = 1'b0;
    step("rt_unused", 1, 1, 0, 0, 0);
    bus.id_uses_rt = 1'b1;
    step("rt_used", 0, 0, 0, 1, 0);
    clear();
    check_counts("rt", 2, 0);

    // lw $3 then beq $3: stall with load in EX, again with load in MEM, then flush.
    bus.ex_mem_read = 1'b1; bus.ex_reg_write = 1'b1; bus.ex_dest = 5'd3;
    bus.id_is_branch = 1'b1; bus.id_rs = 5'd3; bus.id_branch_taken = 1'b1;
    step("beq_load_ex", 0, 0, 0, 1, 0);
    bus.ex_mem_read = 1'b0; bus.ex_reg_write = 1'b0; bus.ex_dest = 5'd0;
    bus.mem_mem_read = 1'b1; bus.mem_dest = 5'd3;
    step("beq_load_mem", 0, 0, 0, 1, 0);
    bus.mem_mem_read = 1'b0; bus.mem_dest = 5'd0;
    step("beq_taken", 1, 1, 1, 0, 0);
    clear();
    step("after_beq", 1, 1, 0, 0, 0);
    check_counts("beq", 4, 1);

    // Branch comparing an ALU result still in EX.
    bus.id_is_branch = 1'b1; bus.ex_reg_write = 1'b1; bus.ex_dest = 5'd7;
    bus.id_rs = 5'd1; bus.id_rt = 5'd7; bus.id_uses_rt = 1'b1;
    step("beq_alu", 0, 0, 0, 1, 0);
    clear();
    check_counts("beq_alu", 5, 0 + 1);

    // Halt, drain, step, resume.
    bus.dbg_halt_req = 1'b1;
    step("halt_req", 1, 1, 0, 0, 0);
    clear();
    load_use_inputs();
    step("drain0", 0, 0, 0, 1, 0);
    bus.dbg_step_req = 1'b1;
    step("drain1_step_ignored", 0, 0, 0, 1, 0);
    bus.dbg_step_req = 1'b0;
    step("drain2", 0, 0, 0, 1, 0);
    step("halted", 0, 0, 0, 1, 1);
    bus.dbg_halt_req = 1'b1;
    step("halted_halt_ignored", 0, 0, 0, 1, 1);
    clear();
    check_counts("halted", 5, 1);
    bus.id_branch_taken = 1'b1;
    bus.dbg_step_req = 1'b1;
    step("step_req", 0, 0, 0, 1, 1);
    bus.dbg_step_req = 1'b0;
    step("step_cycle", 1, 1, 1, 0, 0);
    clear();
    step("rehalted", 0, 0, 0, 1, 1);
    check_counts("step", 5, 2);
    bus.dbg_resume_req = 1'b1; bus.dbg_step_req = 1'b1;
    step("resume_wins", 0, 0, 0, 1, 1);
    clear();
    step("run_again", 1, 1, 0, 0, 0);
    step("run_again2", 1, 1, 0, 0, 0);

    // Asynchronous reset in the middle of a drain.
    bus.dbg_halt_req = 1'b1;
    step("halt_req2", 1, 1, 0, 0, 0);
    clear();
    step("drain0_b", 0, 0, 0, 1, 0);
    #2 reset = 1'b1;
    #1;
    sb.push_back('{"reset_mid_drain", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    compare_head();
    check_counts("reset_mid_drain", 0, 0);
    @(posedge clk); #3 reset = 1'b0;
    @(posedge clk); #1;
    step("post_reset0", 1, 1, 0, 0, 0);
    step("post_reset1", 1, 1, 0, 0, 0);
    step("post_reset2", 1, 1, 0, 0, 0);
    step("post_reset3", 1, 1, 0, 0, 0);

    // Saturation of the stall counter.
    load_use_inputs();
    repeat (65534) begin
      @(posedge clk); #1;
    end
    check({"sat_minus_one", ".stall_count"}, {16'd0, bus.stall_count}, 32'h0000_FFFE);
    @(posedge clk); #1;
    check({"sat", ".stall_count"}, {16'd0, bus.stall_count}, 32'h0000_FFFF);
    @(posedge clk); #1;
    check({"sat_hold", ".stall_count"}, {16'd0, bus.stall_count}, 32'h0000_FFFF);
    check({"sat_hold", ".flush_count"}, {16'd0, bus.flush_count}, 32'h0000_0000);
    clear();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
